// File: rtl/debug_scan_pkg.sv
// Shared types and defaults for the debug scan bridge.
//   - scan_state_e : bridge scan state (IDLE/SHIFT/ARMED)
//   - strobe_e     : the single strobe that acts in a cycle
//   - strobe_pick  : fixed priority uir > udr > cdr > sdr
package debug_scan_pkg;

    localparam int unsigned IR_W_DEF = 2;
    localparam int unsigned DR_W_DEF = 38;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ARMED = 2'd2
    } scan_state_e;

    typedef enum logic [2:0] {
        STB_NONE = 3'd0,
        STB_UIR  = 3'd1,
        STB_UDR  = 3'd2,
        STB_CDR  = 3'd3,
        STB_SDR  = 3'd4
    } strobe_e;

    // Reduce the four strobes to the one that wins this cycle.
    function automatic strobe_e strobe_pick(input logic uir, input logic udr,
                                            input logic cdr, input logic sdr);
        strobe_e s;
        s = STB_NONE;
        if (uir)      s = STB_UIR;
        else if (udr) s = STB_UDR;
        else if (cdr) s = STB_CDR;
        else if (sdr) s = STB_SDR;
        return s;
    endfunction

endpackage

// File: rtl/debug_scan_shift.sv
// Scan data register with saturating shift counter.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   load, load_val - parallel capture (clears cnt)
//   shift, tdi     - shift one bit in at the MSB end
//   clr_cnt        - zero the shift counter
//   sr, cnt        - register contents and shift count
module debug_scan_shift
    import debug_scan_pkg::*;
#(
    parameter  int unsigned DR_W  = DR_W_DEF,
    localparam int unsigned CNT_W = $clog2(DR_W + 2)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DR_W-1:0]  load_val,
    input  logic             shift,
    input  logic             tdi,
    input  logic             clr_cnt,
    output logic [DR_W-1:0]  sr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DR_W + 1);

    // Counter saturates one past a full scan so any overshift stays detectable.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_val;
            cnt <= '0;
        end else if (clr_cnt) begin
            cnt <= '0;
        end else if (shift) begin
            sr <= {tdi, sr[DR_W-1:1]};
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/debug_scan_bridge.sv
// Debug scan bridge: virtual-JTAG style IR/DR scan into per-channel action pulses.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   vs_uir, ir_in              - update-IR strobe and instruction value
//   vs_cdr, vs_sdr, vs_udr     - capture / shift / update DR strobes
//   tdi, tdo                   - serial in, serial out (tdo = sr[0], combinational)
//   cap_data                   - packed per-channel capture payload
//   ch_busy                    - per-channel busy; update to a busy channel is an overrun
//   clear_err                  - clears sticky overrun / short_scan
//   ir_q, jdo                  - latched instruction, last accepted data register
//   take_action/take_no_action - one-cycle per-channel pulses on an accepted update
//   overrun, short_scan        - sticky error flags
module debug_scan_bridge
    import debug_scan_pkg::*;
#(
    parameter  int unsigned IR_W   = IR_W_DEF,
    parameter  int unsigned DR_W   = DR_W_DEF,
    localparam int unsigned NUM_CH = 2 ** IR_W,
    localparam int unsigned CAP_W  = DR_W - 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vs_uir,
    input  logic [IR_W-1:0]         ir_in,
    input  logic                    vs_cdr,
    input  logic                    vs_sdr,
    input  logic                    vs_udr,
    input  logic                    tdi,
    input  logic [NUM_CH*CAP_W-1:0] cap_data,
    input  logic [NUM_CH-1:0]       ch_busy,
    input  logic                    clear_err,
    output logic                    tdo,
    output logic [IR_W-1:0]         ir_q,
    output logic [DR_W-1:0]         jdo,
    output logic [NUM_CH-1:0]       take_action,
    output logic [NUM_CH-1:0]       take_no_action,
    output logic                    overrun,
    output logic                    short_scan
);

    localparam int unsigned CNT_W = $clog2(DR_W + 2);

    strobe_e          strobe_c;
    scan_state_e      state, state_nxt;
    logic [DR_W-1:0]  sr;
    logic [CNT_W-1:0] cnt;
    logic [CAP_W-1:0] cap_slice_c;
    logic             count_ok_c;
    logic             upd_fire_c;
    logic             upd_short_c;
    logic             upd_ovr_c;

    assign strobe_c    = strobe_pick(vs_uir, vs_udr, vs_cdr, vs_sdr);
    assign cap_slice_c = cap_data[32'(ir_q) * CAP_W +: CAP_W];
    assign tdo         = sr[0];

    debug_scan_shift #(.DR_W(DR_W)) u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (strobe_c == STB_CDR),
        .load_val ({overrun, short_scan, cap_slice_c}),
        .shift    (strobe_c == STB_SDR),
        .tdi      (tdi),
        .clr_cnt  (strobe_c == STB_UDR),
        .sr       (sr),
        .cnt      (cnt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state: an sdr that lands on DR_W arms; any other sdr (incl. overshift) is SHIFT.
    always_comb begin
        state_nxt = state;
        case (strobe_c)
            STB_UIR, STB_UDR: state_nxt = ST_IDLE;
            STB_CDR:          state_nxt = ST_SHIFT;
            STB_SDR:          state_nxt = (cnt == CNT_W'(DR_W - 1)) ? ST_ARMED : ST_SHIFT;
            default:          state_nxt = state;
        endcase
    end

    // Update qualification. uir parks in IDLE without touching cnt, so a full
    // count can still be pending there.
    always_comb begin
        count_ok_c  = 1'b0;
        upd_fire_c  = 1'b0;
        upd_short_c = 1'b0;
        upd_ovr_c   = 1'b0;
        count_ok_c  = (state == ST_ARMED) ||
                      ((state == ST_IDLE) && (cnt == CNT_W'(DR_W)));
        if (strobe_c == STB_UDR) begin
            if (!count_ok_c)         upd_short_c = 1'b1;
            else if (ch_busy[ir_q])  upd_ovr_c   = 1'b1;
            else                     upd_fire_c  = 1'b1;
        end
    end

    // Instruction, data register, pulses and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q           <= '0;
            jdo            <= '0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
            short_scan     <= 1'b0;
        end else begin
            take_action    <= '0;
            take_no_action <= '0;
            if (strobe_c == STB_UIR) ir_q <= ir_in;
            if (upd_fire_c) begin
                jdo <= sr;
                if (sr[DR_W-1]) take_action    <= NUM_CH'(1) << ir_q;
                else            take_no_action <= NUM_CH'(1) << ir_q;
            end
            // A set in the same cycle as clear_err wins.
            overrun    <= upd_ovr_c   | (overrun    & ~clear_err);
            short_scan <= upd_short_c | (short_scan & ~clear_err);
        end
    end

endmodule
